dma_copy_engine: RTL and testbench

DMA_COPY_ENGINE -- requirements
Module: dma_copy_engine

---
 rtl/eei_pkg.sv | 13 +
 rtl/membus.sv | 17 +
 rtl/dma_copy_engine_addr_gen.sv | 52 +++++
 rtl/dma_copy_engine.sv | 184 ++++++++++++++++++
 tb/tb_dma_copy_engine.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/eei_pkg.sv
// Shared execution-environment package: DMA state encoding and word geometry.
`timescale 1ns/1ps
package eei_pkg;
  localparam int DMA_XLEN       = 64;
  localparam int DMA_WORD_BYTES = DMA_XLEN / 8;

  typedef enum logic [1:0] {
    D_IDLE    = 2'd0,
    D_RD_REQ  = 2'd1,
    D_RD_WAIT = 2'd2,
    D_WR_REQ  = 2'd3
  } dma_state_t;
endpackage

// File: rtl/membus.sv
// Simple memory bus: one request channel (valid/ready) plus a read-return strobe.
`timescale 1ns/1ps
interface Membus #(
  parameter int XLEN = 64
);
  logic              valid;
  logic              ready;
  logic [XLEN-1:0]   addr;
  logic              wen;
  logic [XLEN-1:0]   wdata;
  logic [XLEN/8-1:0] wmask;
  logic              rvalid;
  logic [XLEN-1:0]   rdata;

  modport master (output valid, addr, wen, wdata, wmask, input ready, rvalid, rdata);
  modport slave  (input valid, addr, wen, wdata, wmask, output ready, rvalid, rdata);
endinterface

// File: rtl/dma_copy_engine_addr_gen.sv
// dma_addr_gen: source/destination pointers and completed-word counter.
// Pointers advance one word per completed write and wrap modulo 2^XLEN.
`timescale 1ns/1ps
module dma_addr_gen
  import eei_pkg::*;
#(
  parameter int XLEN = DMA_XLEN
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_load,
  input  logic [XLEN-1:0] i_src,
  input  logic [XLEN-1:0] i_dst,
  input  logic [31:0]     i_len,
  input  logic            i_inc,
  output logic [XLEN-1:0] o_src,
  output logic [XLEN-1:0] o_dst,
  output logic [31:0]     o_words,
  output logic            o_last
);
  localparam logic [XLEN-1:0] STEP = XLEN'(XLEN / 8);

  logic [XLEN-1:0] r_src;
  logic [XLEN-1:0] r_dst;
  logic [31:0]     r_len;
  logic [31:0]     r_words;

  // Load a fresh job on start, otherwise step after each completed write
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_src   <= '0;
      r_dst   <= '0;
      r_len   <= '0;
      r_words <= '0;
    end else if (i_load) begin
      r_src   <= i_src;
      r_dst   <= i_dst;
      r_len   <= i_len;
      r_words <= '0;
    end else if (i_inc) begin
      r_src   <= r_src + STEP;
      r_dst   <= r_dst + STEP;
      r_words <= r_words + 32'd1;
    end
  end

  assign o_src   = r_src;
  assign o_dst   = r_dst;
  assign o_words = r_words;
  // The word currently being written is the final one
  assign o_last  = (r_words + 32'd1) == r_len;
endmodule

// File: rtl/dma_copy_engine.sv
// dma_copy_engine: word-by-word memory copy over a Membus master port.
// Each word is one read (RD_REQ, wait for rvalid) followed by one write.
// Optional macro DMA_ALIGN_CHECK_EN: misaligned start addresses raise err
// instead of being silently rounded down to a word boundary.
`timescale 1ns/1ps
module dma_copy_engine
  import eei_pkg::*;
#(
  parameter int XLEN = DMA_XLEN
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [XLEN-1:0] i_src_addr,
  input  logic [XLEN-1:0] i_dst_addr,
  input  logic [31:0]     i_len,
  input  logic            i_abort,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_err,
  output logic [31:0]     o_words_done,
  Membus.master           bus
);
  localparam int              WB       = XLEN / 8;
  localparam logic [XLEN-1:0] LOW_MASK = XLEN'(WB - 1);

  dma_state_t      r_state, w_next;
  logic [XLEN-1:0] r_buf;
  logic            r_done;
  logic            r_err;
  logic            r_abort_pend;

  logic            w_accept;
  logic            w_misalign;
  logic [XLEN-1:0] w_src_ld;
  logic [XLEN-1:0] w_dst_ld;
  logic            w_fire;
  logic            w_inc;
  logic            w_fin;
  logic            w_capture;
  logic            w_pend_set;
  logic            w_valid;
  logic            w_wen;
  logic [XLEN-1:0] w_addr;
  logic [XLEN-1:0] w_wdata;
  logic [WB-1:0]   w_wmask;
  logic [XLEN-1:0] w_src;
  logic [XLEN-1:0] w_dst;
  logic [31:0]     w_words;
  logic            w_last;

  assign w_accept = i_start && (r_state == D_IDLE);
  assign w_fire   = w_valid && bus.ready;

`ifdef DMA_ALIGN_CHECK_EN
  assign w_misalign = |((i_src_addr | i_dst_addr) & LOW_MASK);
  assign w_src_ld   = i_src_addr;
  assign w_dst_ld   = i_dst_addr;
`else
  assign w_misalign = 1'b0;
  assign w_src_ld   = i_src_addr & ~LOW_MASK;
  assign w_dst_ld   = i_dst_addr & ~LOW_MASK;
`endif

  dma_addr_gen #(.XLEN(XLEN)) u_addr_gen (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (w_accept),
    .i_src   (w_src_ld),
    .i_dst   (w_dst_ld),
    .i_len   (i_len),
    .i_inc   (w_inc),
    .o_src   (w_src),
    .o_dst   (w_dst),
    .o_words (w_words),
    .o_last  (w_last)
  );

  // State register
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_state <= D_IDLE;
    else        r_state <= w_next;
  end

  // Next state and bus drive; bus outputs are all-zero outside request states
  always_comb begin
    w_next     = r_state;
    w_valid    = 1'b0;
    w_wen      = 1'b0;
    w_addr     = '0;
    w_wdata    = '0;
    w_wmask    = '0;
    w_inc      = 1'b0;
    w_fin      = 1'b0;
    w_capture  = 1'b0;
    w_pend_set = 1'b0;
    case (r_state)
      D_IDLE: begin
        if (w_accept && !w_misalign && (i_len != 32'd0)) w_next = D_RD_REQ;
      end
      D_RD_REQ: begin
        w_valid = 1'b1;
        w_addr  = w_src;
        if (w_fire) begin
          // A read in flight must still be drained before stopping
          w_next     = D_RD_WAIT;
          w_pend_set = i_abort;
        end else if (i_abort) begin
          w_next = D_IDLE;
          w_fin  = 1'b1;
        end
      end
      D_RD_WAIT: begin
        if (bus.rvalid) begin
          if (r_abort_pend || i_abort) begin
            w_next = D_IDLE;
            w_fin  = 1'b1;
          end else begin
            w_capture = 1'b1;
            w_next    = D_WR_REQ;
          end
        end else begin
          w_pend_set = i_abort;
        end
      end
      D_WR_REQ: begin
        w_valid = 1'b1;
        w_wen   = 1'b1;
        w_addr  = w_dst;
        w_wdata = r_buf;
        w_wmask = '1;
        if (w_fire) begin
          w_inc = 1'b1;
          if (w_last || i_abort || r_abort_pend) begin
            w_next = D_IDLE;
            w_fin  = 1'b1;
          end else begin
            w_next = D_RD_REQ;
          end
        end else if (i_abort) begin
          w_next = D_IDLE;
          w_fin  = 1'b1;
        end
      end
      default: w_next = D_IDLE;
    endcase
  end

  // Remember an abort that arrived while a read was still outstanding
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)                r_abort_pend <= 1'b0;
    else if (w_next == D_IDLE) r_abort_pend <= 1'b0;
    else if (w_pend_set)       r_abort_pend <= 1'b1;
  end

  // Data buffer holds the read word until its write completes
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)         r_buf <= '0;
    else if (w_capture) r_buf <= bus.rdata;
  end

  // Completion pulse: end of a job, or a start that needs no bus traffic
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_done <= 1'b0;
    else        r_done <= w_fin || (w_accept && (w_misalign || (i_len == 32'd0)));
  end

  // Sticky error, re-evaluated on every accepted start
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)        r_err <= 1'b0;
    else if (w_accept) r_err <= w_misalign;
  end

  assign o_busy       = (r_state != D_IDLE);
  assign o_done       = r_done;
  assign o_err        = r_err;
  assign o_words_done = w_words;

  assign bus.valid = w_valid;
  assign bus.wen   = w_wen;
  assign bus.addr  = w_addr;
  assign bus.wdata = w_wdata;
  assign bus.wmask = w_wmask;
endmodule

// File: tb/tb_dma_copy_engine.sv
// Scoreboard bench for dma_copy_engine: a job model pushes the expected bus
// transactions and completion record; a monitor pops and compares them.
`timescale 1ns/1ps
module tb_dma_copy_engine;
  import eei_pkg::*;
  localparam int XLEN = DMA_XLEN;
  localparam int WB   = DMA_WORD_BYTES;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic [XLEN-1:0] src_addr = '0;
  logic [XLEN-1:0] dst_addr = '0;
  logic [31:0]     len = '0;
  logic            busy, done, err;
  logic [31:0]     words_done;

  Membus #(.XLEN(XLEN)) bus ();

  dma_copy_engine #(.XLEN(XLEN)) dut (
    .i_clk(clk), .i_rst(rst_n), .i_start(start), .i_src_addr(src_addr),
    .i_dst_addr(dst_addr), .i_len(len), .i_abort(abort), .o_busy(busy),
    .o_done(done), .o_err(err), .o_words_done(words_done), .bus(bus.master)
  );

  always #10 clk = ~clk;

  typedef struct { logic [63:0] addr; logic wen; logic [63:0] wdata; } txn_t;
  typedef struct { int words; logic err; int busy; bit lat; } cpl_t;
  txn_t exp_q[$];
  cpl_t cpl_q[$];
  int tests = 0, fails = 0;
  int cyc = 0, rd_fires = 0, last_fire_cyc = -10;

  function automatic logic [63:0] pat(input logic [63:0] a);
    return (a * 64'h9E3779B97F4A7C15) ^ 64'h0123_4567_89AB_CDEF;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- bus slave ----------------
  int ready_mode = 0;  // 0 always, 1 random, 2 never, 3 never for writes
  int rd_lat = 1, rd_cnt = 0, bp_cnt = 0;
  bit bp_arm = 0, bp_used = 0, stray = 0;
  logic [63:0] rd_addr;
  logic [63:0] mem [logic [63:0]];

  initial begin
    bus.ready = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0;
  end

  always begin
    @(negedge clk); #1;
    if (!rst_n) begin
      rd_cnt = 0; bp_cnt = 0; bus.ready = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0;
    end else begin
      bus.rvalid = 1'b0; bus.rdata = '0;
      if (rd_cnt > 0) begin
        rd_cnt--;
        if (rd_cnt == 0) begin bus.rvalid = 1'b1; bus.rdata = pat(rd_addr); end
      end
      if (stray) begin bus.rvalid = 1'b1; bus.rdata = 64'hBAD0_BAD0_BAD0_BAD0; stray = 0; end
      if (bp_arm && !bp_used && bus.valid && bus.wen && bus.addr == 64'h2008) begin
        bp_cnt = 5; bp_used = 1;
      end
      if (bp_cnt > 0) begin bus.ready = 1'b0; bp_cnt--; end
      else case (ready_mode)
        1: bus.ready = ($urandom_range(0, 3) != 0);
        2: bus.ready = 1'b0;
        3: bus.ready = !(bus.valid && bus.wen);
        default: bus.ready = 1'b1;
      endcase
      // ready now set for the coming edge: a handshake will occur there
      if (bus.valid && bus.ready) begin
        if (!bus.wen) begin rd_cnt = rd_lat; rd_addr = bus.addr; end
        else mem[bus.addr] = bus.wdata;
      end
    end
  end

  // ---------------- monitor ----------------
  logic pv = 0, pw;
  logic [63:0] pa, pd;
  int busy_cnt = 0;

  always begin
    @(negedge clk); #3;
    cyc++;
    if (!rst_n) begin
      pv = 0; busy_cnt = 0;
    end else begin
      if (pv) begin
        chk("stall_valid", bus.valid, 1'b1);
        chk("stall_addr", bus.addr, pa);
        chk("stall_wen", bus.wen, pw);
        chk("stall_wdata", bus.wdata, pd);
      end
      if (done) begin
        chk("done_not_busy", busy, 1'b0);
        if (cpl_q.size() == 0) begin
          fails++; tests++;
          $display("FAIL unexpected_done: got done=1 expected no completion");
        end else begin
          cpl_t c;
          c = cpl_q.pop_front();
          chk("cpl_words_done", words_done, c.words);
          chk("cpl_err", err, c.err);
          if (c.busy >= 0) chk("cpl_busy_cycles", busy_cnt, c.busy);
          if (c.lat) chk("cpl_done_latency", cyc - last_fire_cyc, 1);
        end
        busy_cnt = 0;
      end
      if (busy) busy_cnt++;
      if (bus.valid && exp_q.size() == 0) begin
        fails++; tests++;
        $display("FAIL unexpected_valid: got valid addr=%h wen=%b expected idle bus", bus.addr, bus.wen);
      end else if (bus.valid && bus.ready) begin
        txn_t t;
        t = exp_q.pop_front();
        chk("txn_addr", bus.addr, t.addr);
        chk("txn_wen", bus.wen, t.wen);
        if (t.wen) begin
          chk("txn_wdata", bus.wdata, t.wdata);
          chk("txn_wmask", bus.wmask, 8'hFF);
        end else rd_fires++;
        last_fire_cyc = cyc;
      end
      pv = bus.valid && !bus.ready && !abort;
      pa = bus.addr; pw = bus.wen; pd = bus.wdata;
    end
  end

  // ---------------- reference model + stimulus ----------------
  task automatic wait_cpl(input string nm, input int limit);
    int n = 0;
    while (cpl_q.size() != 0 && n < limit) begin @(negedge clk); #1; n++; end
    if (cpl_q.size() != 0) begin
      fails++; tests++;
      $display("FAIL %s_timeout: got %0d pending completions expected 0", nm, cpl_q.size());
      cpl_q.delete(); exp_q.delete();
    end
  endtask

  task automatic run_job(input logic [63:0] s, input logic [63:0] d, input int n,
                         input int bexp, input bit lat, input bit inj);
    logic [63:0] es, ed;
    bit imm;
    int k;
    cpl_t c;
    imm = (n == 0);
    es = s & ~64'(WB - 1);
    ed = d & ~64'(WB - 1);
`ifdef DMA_ALIGN_CHECK_EN
    if (((s | d) & 64'(WB - 1)) != 0) begin
      imm = 1;
      c = '{0, 1'b1, 0, 1'b0};
    end else
`endif
    begin
      for (int i = 0; i < n; i++) begin
        exp_q.push_back('{es + 64'(i * WB), 1'b0, 64'h0});
        exp_q.push_back('{ed + 64'(i * WB), 1'b1, pat(es + 64'(i * WB))});
      end
      c = '{n, 1'b0, (imm ? 0 : bexp), lat && !imm};
    end
    cpl_q.push_back(c);
    @(negedge clk); #1;
    start = 1; src_addr = s; dst_addr = d; len = n;
    @(negedge clk); #1;
    start = 0; src_addr = {$urandom, $urandom}; dst_addr = {$urandom, $urandom}; len = $urandom;
    if (imm) begin #2; chk("immediate_done", done, 1'b1); chk("immediate_idle", busy, 1'b0); end
    k = 0;
    while (cpl_q.size() != 0 && k < 3000) begin
      if (inj && k == 4 && busy) begin
        start = 1; src_addr = 64'h9000; dst_addr = 64'hA000; len = 1;
        @(negedge clk); #1; start = 0; k++;
      end else begin
        @(negedge clk); #1; k++;
      end
    end
    if (cpl_q.size() != 0) begin
      fails++; tests++;
      $display("FAIL job_timeout: got %0d pending completions expected 0", cpl_q.size());
      cpl_q.delete(); exp_q.delete();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base, k;
    repeat (3) @(negedge clk);
    #5;
    chk("rst_busy", busy, 1'b0); chk("rst_done", done, 1'b0); chk("rst_err", err, 1'b0);
    chk("rst_words", words_done, 0); chk("rst_valid", bus.valid, 1'b0);
    @(negedge clk); #1; rst_n = 1;

    // basic copy, 3 cycles per word
    ready_mode = 0; rd_lat = 1;
    run_job(64'h1000, 64'h2000, 4, 12, 1, 0);
    for (int i = 0; i < 4; i++)
      chk("basic_dst_word", mem.exists(64'h2000 + 64'(i * 8)) ? mem[64'h2000 + 64'(i * 8)] : 64'hX,
          pat(64'h1000 + 64'(i * 8)));

    // zero length
    run_job(64'h1000, 64'h2000, 0, 0, 0, 0);

    // back-pressure on the write of word 1
    bp_arm = 1; bp_used = 0;
    run_job(64'h1000, 64'h2000, 4, 17, 1, 0);
    chk("bp_stall_seen", bp_used, 1'b1);
    bp_arm = 0;

    // pointer wrap across 2^64
    run_job(64'hFFFF_FFFF_FFFF_FFF0, 64'hFFFF_FFFF_FFFF_FFE8, 4, 12, 1, 0);

    // abort while waiting for the read of word 2
    rd_lat = 3;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back('{64'h5000 + 64'(i * 8), 1'b0, 64'h0});
      exp_q.push_back('{64'h6000 + 64'(i * 8), 1'b1, pat(64'h5000 + 64'(i * 8))});
    end
    exp_q.push_back('{64'h5010, 1'b0, 64'h0});
    cpl_q.push_back('{2, 1'b0, -1, 1'b0});
    base = rd_fires;
    @(negedge clk); #1; start = 1; src_addr = 64'h5000; dst_addr = 64'h6000; len = 8;
    @(negedge clk); #1; start = 0;
    k = 0;
    while (rd_fires != base + 3 && k < 200) begin @(negedge clk); #1; k++; end
    chk("abort_third_read", rd_fires - base, 3);
    abort = 1; @(negedge clk); #1; abort = 0;
    wait_cpl("abort_rdwait", 200);
    chk("abort_no_write", mem.exists(64'h6010), 1'b0);
    rd_lat = 1;

    // abort while a read request is stalled
    ready_mode = 2;
    exp_q.push_back('{64'h7000, 1'b0, 64'h0});
    cpl_q.push_back('{0, 1'b0, 3, 1'b0});
    @(negedge clk); #1; start = 1; src_addr = 64'h7000; dst_addr = 64'h7800; len = 3;
    @(negedge clk); #1; start = 0;
    repeat (2) begin @(negedge clk); #1; end
    abort = 1; @(negedge clk); #1; abort = 0;
    wait_cpl("abort_rdreq", 20);
    chk("abort_rdreq_pending", exp_q.size(), 1);
    exp_q.delete();
    ready_mode = 0;

    // reset while a write is stalled
    ready_mode = 3;
    exp_q.push_back('{64'h4000, 1'b0, 64'h0});
    exp_q.push_back('{64'h5800, 1'b1, pat(64'h4000)});
    @(negedge clk); #1; start = 1; src_addr = 64'h4000; dst_addr = 64'h5800; len = 4;
    @(negedge clk); #1; start = 0;
    k = 0;
    while (!(bus.valid && bus.wen) && k < 50) begin @(negedge clk); #1; k++; end
    chk("reset_reached_write", bus.valid && bus.wen, 1'b1);
    #4 rst_n = 0;
    #1;
    chk("mid_rst_busy", busy, 1'b0); chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_err", err, 1'b0); chk("mid_rst_words", words_done, 0);
    chk("mid_rst_valid", bus.valid, 1'b0); chk("mid_rst_addr", bus.addr, 0);
    chk("mid_rst_wen", bus.wen, 1'b0); chk("mid_rst_wdata", bus.wdata, 0);
    chk("mid_rst_wmask", bus.wmask, 0);
    exp_q.delete(); cpl_q.delete();
    ready_mode = 0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1; stray = 1;
    repeat (3) begin @(negedge clk); #1; end
    chk("post_rst_idle", busy, 1'b0);
    run_job(64'h1100, 64'h2100, 2, 6, 1, 0);

    // alignment handling
    run_job(64'h1004, 64'h3000, 2, 6, 1, 0);
    run_job(64'h1000, 64'h3000, 1, 3, 1, 0);

    // randomized jobs
    ready_mode = 1;
    for (int j = 0; j < 10; j++) begin
      logic [63:0] s, d;
      s = {$urandom, $urandom};
      d = {$urandom, $urandom};
`ifdef DMA_ALIGN_CHECK_EN
      if (j != 3) begin s[2:0] = 3'b0; d[2:0] = 3'b0; end
`endif
      rd_lat = $urandom_range(1, 3);
      run_job(s, d, $urandom_range(0, 6), -1, 0, j[0]);
    end

    repeat (3) @(negedge clk);
    #2 chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
